// File: rtl/lcd_demo_pkg.sv
// Shared definitions for the LCD CPU demo: FSM states, ALU operations and
// the width of each field packed into the displayed instruction word.
package lcd_demo_pkg;

    // Processor sequencing states; the value doubles as the LED bit position.
    typedef enum logic [1:0] {
        StFetch     = 2'd0,
        StDecode    = 2'd1,
        StExecute   = 2'd2,
        StWriteback = 2'd3
    } state_e;

    // ALU operation, taken from SWI[3:2].
    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpAnd = 2'd2,
        OpOr  = 2'd3
    } alu_op_e;

    // Every field of the displayed instruction is zero-extended to this width.
    localparam int unsigned FieldW = 8;

    // Width of the state one-hot on LED[3:0].
    localparam int unsigned StateOhW = 4;

endpackage

// File: rtl/lcd_regfile.sv
// Register file for the LCD CPU demo.
// One synchronous write port and a full parallel read of every register.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset; register i resets to i
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   regs_o   - all register contents, no added latency
module lcd_regfile #(
    parameter int unsigned NBits = 8,
    parameter int unsigned NRegs = 32,
    parameter int unsigned IdxW  = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [IdxW-1:0]             waddr_i,
    input  logic [NBits-1:0]            wdata_i,
    output logic [NRegs-1:0][NBits-1:0] regs_o
);

    logic [NRegs-1:0][NBits-1:0] regs_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NRegs); i++) begin
                regs_q[i] <= NBits'(i);
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign regs_o = regs_q;

endmodule

// File: rtl/lcd_cpu_demo.sv
// Four-state teaching CPU whose whole datapath is exposed for an LCD.
// Each instruction reads reg[pc], reg[pc+1], writes reg[pc+2] with an ALU
// result selected by SWI[3:2], then advances pc.
// Ports:
//   clk_2, reset        - clock, asynchronous active-high reset
//   SWI                 - SWI[0] run, SWI[1] step (rising edge), SWI[3:2] ALU op
//   LED                 - one-hot FSM state on LED[3:0]
//   SEG                 - program counter
//   lcd_a / lcd_b       - retired-instruction / cycle counters
//   lcd_instruction     - {rd, rs2, rs1, op}, 8 bits per field
//   lcd_registrador     - register file contents
//   lcd_* (others)      - datapath and control taps
import lcd_demo_pkg::*;

module lcd_cpu_demo #(
    parameter int unsigned NBITS_TOP   = 8,
    parameter int unsigned NREGS_TOP   = 32,
    parameter int unsigned NBITS_LCD   = 64,
    parameter int unsigned NINSTR_BITS = 32
) (
    input  logic                                clk_2,
    input  logic                                reset,
    input  logic [NBITS_TOP-1:0]                SWI,
    output logic [NBITS_TOP-1:0]                LED,
    output logic [NBITS_TOP-1:0]                SEG,
    output logic [NBITS_LCD-1:0]                lcd_a,
    output logic [NBITS_LCD-1:0]                lcd_b,
    output logic [NINSTR_BITS-1:0]              lcd_instruction,
    output logic [NREGS_TOP-1:0][NBITS_TOP-1:0] lcd_registrador,
    output logic [NBITS_TOP-1:0]                lcd_pc,
    output logic [NBITS_TOP-1:0]                lcd_SrcA,
    output logic [NBITS_TOP-1:0]                lcd_SrcB,
    output logic [NBITS_TOP-1:0]                lcd_ALUResult,
    output logic [NBITS_TOP-1:0]                lcd_Result,
    output logic [NBITS_TOP-1:0]                lcd_WriteData,
    output logic [NBITS_TOP-1:0]                lcd_ReadData,
    output logic                                lcd_MemWrite,
    output logic                                lcd_Branch,
    output logic                                lcd_MemtoReg,
    output logic                                lcd_RegWrite
);

    localparam int unsigned IdxW = (NREGS_TOP > 1) ? $clog2(NREGS_TOP) : 1;

    state_e                         state_q, state_d;
    alu_op_e                        op_q;
    logic [NBITS_TOP-1:0]           pc_q;
    logic [NBITS_TOP-1:0]           srca_q, srcb_q, alu_q, alu_d;
    logic [NBITS_TOP-1:0]           result_q, wdata_q, rdata_q;
    logic [NINSTR_BITS-1:0]         instr_q, instr_d;
    logic                           branch_q;
    logic [NBITS_LCD-1:0]           a_q, b_q;
    logic                           swi1_q;
    logic                           step;
    logic                           go;
    logic                           reg_we;
    logic [IdxW-1:0]                rs1, rs2, rd;
    logic [NREGS_TOP-1:0][NBITS_TOP-1:0] regs;
    logic [StateOhW-1:0]            state_oh;

    // NREGS_TOP is a power of two, so truncation is the modulo.
    assign rs1 = IdxW'(pc_q);
    assign rs2 = rs1 + IdxW'(1);
    assign rd  = rs1 + IdxW'(2);

    // Step pulses are only consumed in FETCH; elsewhere they fall on the floor.
    assign step = SWI[1] & ~swi1_q;
    assign go   = SWI[0] | step;

    assign instr_d = NINSTR_BITS'({FieldW'(rd), FieldW'(rs2), FieldW'(rs1),
                                   FieldW'(SWI[3:2])});

    assign reg_we = (state_q == StWriteback);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:     if (go) state_d = StDecode;
            StDecode:    state_d = StExecute;
            StExecute:   state_d = StWriteback;
            StWriteback: state_d = StFetch;
            default:     state_d = StFetch;
        endcase
    end

    always_comb begin
        alu_d = '0;
        unique case (op_q)
            OpAdd:   alu_d = srca_q + srcb_q;
            OpSub:   alu_d = srca_q - srcb_q;
            OpAnd:   alu_d = srca_q & srcb_q;
            OpOr:    alu_d = srca_q | srcb_q;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q  <= StFetch;
            op_q     <= OpAdd;
            pc_q     <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            alu_q    <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            instr_q  <= '0;
            branch_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            swi1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_q + NBITS_LCD'(1);
            swi1_q  <= SWI[1];
            unique case (state_q)
                StDecode: begin
                    // Operands are captured here so later SWI changes and
                    // rd aliasing cannot disturb the instruction in flight.
                    op_q    <= alu_op_e'(SWI[3:2]);
                    srca_q  <= regs[rs1];
                    srcb_q  <= regs[rs2];
                    rdata_q <= regs[rd];
                    instr_q <= instr_d;
                end
                StExecute: begin
                    alu_q    <= alu_d;
                    branch_q <= (alu_d == '0);
                end
                StWriteback: begin
                    result_q <= alu_q;
                    wdata_q  <= alu_q;
                    pc_q     <= pc_q + NBITS_TOP'(1);
                    a_q      <= a_q + NBITS_LCD'(1);
                end
                default: ;
            endcase
        end
    end

    lcd_regfile #(
        .NBits (NBITS_TOP),
        .NRegs (NREGS_TOP),
        .IdxW  (IdxW)
    ) u_regfile (
        .clk_i   (clk_2),
        .rst_i   (reset),
        .we_i    (reg_we),
        .waddr_i (rd),
        .wdata_i (alu_q),
        .regs_o  (regs)
    );

    assign state_oh = StateOhW'(1) << state_q;

    assign LED             = NBITS_TOP'(state_oh);
    assign SEG             = pc_q;
    assign lcd_a           = a_q;
    assign lcd_b           = b_q;
    assign lcd_instruction = instr_q;
    assign lcd_registrador = regs;
    assign lcd_pc          = pc_q;
    assign lcd_SrcA        = srca_q;
    assign lcd_SrcB        = srcb_q;
    assign lcd_ALUResult   = alu_q;
    assign lcd_Result      = result_q;
    assign lcd_WriteData   = wdata_q;
    assign lcd_ReadData    = rdata_q;
    assign lcd_MemWrite    = 1'b0;
    assign lcd_Branch      = branch_q;
    assign lcd_MemtoReg    = 1'b0;
    assign lcd_RegWrite    = reg_we;

endmodule

// File: tb/tb_lcd_cpu_demo.sv
// Scoreboard bench for lcd_cpu_demo: an instruction-level model pushes the
// expected outcome of each issued instruction; a monitor pops and compares
// whenever the DUT shows a register write.
module tb_lcd_cpu_demo;

    localparam int NB = 8;
    localparam int NR = 32;
    localparam int NL = 64;
    localparam int NI = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NB-1:0]        swi;
    logic [NB-1:0]        led, seg;
    logic [NL-1:0]        la, lb;
    logic [NI-1:0]        instr;
    logic [NR-1:0][NB-1:0] regs;
    logic [NB-1:0]        pc, srca, srcb, alur, res, wd, rdat;
    logic                 mw, br, m2r, rw;

    always #5 clk = ~clk;

    lcd_cpu_demo #(
        .NBITS_TOP   (NB),
        .NREGS_TOP   (NR),
        .NBITS_LCD   (NL),
        .NINSTR_BITS (NI)
    ) dut (
        .clk_2           (clk),
        .reset           (rst),
        .SWI             (swi),
        .LED             (led),
        .SEG             (seg),
        .lcd_a           (la),
        .lcd_b           (lb),
        .lcd_instruction (instr),
        .lcd_registrador (regs),
        .lcd_pc          (pc),
        .lcd_SrcA        (srca),
        .lcd_SrcB        (srcb),
        .lcd_ALUResult   (alur),
        .lcd_Result      (res),
        .lcd_WriteData   (wd),
        .lcd_ReadData    (rdat),
        .lcd_MemWrite    (mw),
        .lcd_Branch      (br),
        .lcd_MemtoReg    (m2r),
        .lcd_RegWrite    (rw)
    );

    typedef struct {
        int          rd;
        logic [7:0]  a, b, r, old, pc_after;
        logic        br;
        logic [31:0] ins;
        longint      cnt_after;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] mregs[NR];
    int         mpc;
    longint     mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mregs[i] = 8'(i);
        mpc  = 0;
        mcnt = 0;
    endtask

    // One instruction at architectural level: read two regs, write the third.
    task automatic issue(input int op);
        exp_t e;
        int r1, r2, rdd;
        r1  = mpc % NR;
        r2  = (r1 + 1) % NR;
        rdd = (r1 + 2) % NR;
        e.a = mregs[r1];
        e.b = mregs[r2];
        case (op)
            0:       e.r = e.a + e.b;
            1:       e.r = e.a - e.b;
            2:       e.r = e.a & e.b;
            default: e.r = e.a | e.b;
        endcase
        e.br       = (e.r == 8'd0);
        e.old      = mregs[rdd];
        e.rd       = rdd;
        e.ins      = {8'(rdd), 8'(r2), 8'(r1), 8'(op)};
        mregs[rdd] = e.r;
        mpc        = (mpc + 1) % 256;
        mcnt++;
        e.pc_after  = 8'(mpc);
        e.cnt_after = mcnt;
        q.push_back(e);
    endtask

    // Monitor: compares taps in WRITEBACK and architectural state one cycle later.
    exp_t cur;
    bit   pend = 1'b0;
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            chk("reg_rd_after_wb", 64'(regs[cur.rd]), 64'(cur.r));
            chk("pc_after_wb", 64'(pc), 64'(cur.pc_after));
            chk("seg_after_wb", 64'(seg), 64'(cur.pc_after));
            chk("lcd_a_after_wb", la, 64'(cur.cnt_after));
            chk("result", 64'(res), 64'(cur.r));
            chk("writedata", 64'(wd), 64'(cur.r));
        end
        if (rw === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_writeback", 64'(rw), 64'(0));
            end else begin
                cur = q.pop_front();
                chk("srca", 64'(srca), 64'(cur.a));
                chk("srcb", 64'(srcb), 64'(cur.b));
                chk("aluresult", 64'(alur), 64'(cur.r));
                chk("branch", 64'(br), 64'(cur.br));
                chk("instruction", 64'(instr), 64'(cur.ins));
                chk("readdata", 64'(rdat), 64'(cur.old));
                chk("led_wb", 64'(led), 64'(8'h08));
                chk("memwrite_memtoreg", 64'({mw, m2r}), 64'(0));
                pend = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] s);
        @(negedge clk);
        rst = 1'b1;
        swi = s;
        model_reset();
        cyc(2);
        rst = 1'b0;
    endtask

    // Run mode for exactly n instructions with a fixed op.
    task automatic run_n(input int op, input int n);
        swi = {4'b0000, 2'(op), 2'b01};
        for (int i = 0; i < n; i++) issue(op);
        cyc(4 * n);
        swi = 8'h00;
        cyc(1);
    endtask

    // One step pulse; the op is scrambled after DECODE has latched it.
    task automatic step(input int op);
        swi = {4'(($urandom & 32'hE)), 2'(op), 2'b10};
        issue(op);
        cyc(1);
        swi[1] = 1'b0;
        cyc(1);
        swi[3:2] = 2'($urandom);
        cyc(2 + $urandom_range(0, 2));
    endtask

    initial begin
        rst = 1'b1;
        swi = 8'h00;
        model_reset();
        cyc(2);
        // Reset state while reset is held.
        chk("reset_led", 64'(led), 64'(8'h01));
        chk("reset_pc", 64'(pc), 64'(0));
        chk("reset_reg5", 64'(regs[5]), 64'(5));
        chk("reset_reg31", 64'(regs[31]), 64'(31));
        chk("reset_counters", la | lb, 64'(0));
        chk("reset_taps", 64'({srca, srcb, alur, res, wd, rdat}), 64'(0));
        chk("reset_ctrl", 64'({mw, br, m2r, rw}), 64'(0));
        chk("reset_instr", 64'(instr), 64'(0));
        rst = 1'b0;
        cyc(1);
        chk("cycle_count_1", lb, 64'(1));
        cyc(1);
        chk("cycle_count_2", lb, 64'(2));
        chk("idle_led", 64'(led), 64'(8'h01));
        chk("idle_pc", 64'(pc), 64'(0));

        // Run ADD from reset release: write lands on the 4th edge.
        do_reset(8'b0000_0001);
        issue(0);
        cyc(3);
        chk("first_wb_timing", 64'(rw), 64'(1));
        swi = 8'h00;
        cyc(1);
        chk("add_reg2", 64'(regs[2]), 64'(1));
        chk("add_lcd_a", la, 64'(1));
        cyc(1);

        do_reset(8'h00);
        run_n(1, 1);
        chk("sub_reg2", 64'(regs[2]), 64'(8'hFF));
        do_reset(8'h00);
        run_n(2, 1);
        chk("and_reg2", 64'(regs[2]), 64'(0));
        chk("and_branch", 64'(br), 64'(1));

        // Single step, then a step edge landing in DECODE.
        do_reset(8'h00);
        cyc(1);
        step(3);
        cyc(5);
        chk("single_step_count", la, 64'(1));
        swi = 8'b0000_0001;
        issue(0);
        cyc(1);
        swi = 8'b0000_0010;
        cyc(10);
        chk("decode_step_ignored", la, 64'(2));
        chk("decode_step_led", 64'(led), 64'(8'h01));
        swi = 8'h00;
        cyc(1);

        // Randomised mix of steps and short runs.
        do_reset(8'h00);
        cyc(1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) run_n(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            else step(int'($urandom_range(0, 3)));
        end
        cyc(2);

        // pc wraps after 256 instructions; rs1=31 writes reg[1].
        do_reset(8'h00);
        run_n(0, 256);
        chk("pc_wrap", 64'(pc), 64'(0));
        chk("wrap_reg1", 64'(regs[1]), 64'(mregs[1]));

        // Reset during EXECUTE aborts the instruction.
        do_reset(8'h00);
        cyc(1);
        swi = 8'b0000_0001;
        cyc(2);
        chk("exec_led", 64'(led), 64'(8'h04));
        rst = 1'b1;
        swi = 8'h00;
        #1;
        chk("abort_led", 64'(led), 64'(8'h01));
        chk("abort_lcd_a", la, 64'(0));
        chk("abort_reg2", 64'(regs[2]), 64'(2));
        chk("abort_regwrite", 64'(rw), 64'(0));
        cyc(1);
        rst = 1'b0;
        model_reset();
        cyc(3);
        chk("abort_pc", 64'(pc), 64'(0));

        chk("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
